// File: rtl/dma_streamer.sv
// dma_streamer: splits a DMA descriptor into AXI-legal requests honouring
// bus alignment, the 4 KB boundary and the maximum burst length.
module dma_streamer #(
  parameter int ADDR_W     = 32,
  parameter int BYTES_W    = 32,
  parameter int DATA_BYTES = 64,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  go_i,
  input  logic                  abort_i,
  input  logic [ADDR_W-1:0]     desc_addr_i,
  input  logic [BYTES_W-1:0]    desc_bytes_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_W-1:0]     req_addr_o,
  output logic [7:0]            req_alen_o,
  output logic [2:0]            req_size_o,
  output logic [DATA_BYTES-1:0] req_strb_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int LB = $clog2(DATA_BYTES);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_REQ = 2'd2, S_DONE = 2'd3;
  logic [1:0]            r_state, w_next;
  logic [ADDR_W-1:0]     r_cur_addr;
  logic [BYTES_W-1:0]    r_remaining, r_len;
  logic                  r_abort_pend;
  logic                  w_full, w_abort;
  logic [12:0]           w_pg_bytes;
  logic [BYTES_W-1:0]    w_rem_beats, w_pg_beats, w_b0, w_beats, w_len, w_rem_after;
  logic [2:0]            w_nsize;
  logic [7:0]            w_n;
  logic [DATA_BYTES-1:0] w_strb;
  assign w_pg_bytes  = 13'h1000 - {1'b0, r_cur_addr[11:0]};
  assign w_pg_beats  = BYTES_W'(w_pg_bytes >> LB);
  assign w_rem_beats = r_remaining >> LB;
  assign w_b0        = w_rem_beats < w_pg_beats ? w_rem_beats : w_pg_beats;
  assign w_beats     = w_b0 > BYTES_W'(MAX_BEATS) ? BYTES_W'(MAX_BEATS) : w_b0;
  assign w_full      = r_cur_addr[LB-1:0] == '0 && r_remaining >= BYTES_W'(DATA_BYTES);
  // Largest naturally aligned power of two that still fits in what is left
  always_comb begin
    w_nsize = '0;
    for (int s = 1; s <= LB; s++)
      if (r_remaining >= (BYTES_W'(1) << s) && (r_cur_addr & ((ADDR_W'(1) << s) - ADDR_W'(1))) == '0)
        w_nsize = 3'(s);
  end
  assign w_n         = 8'd1 << w_nsize;
  assign w_len       = w_full ? w_beats << LB : BYTES_W'(1) << w_nsize;
  assign w_strb      = w_full ? '1 : ~({DATA_BYTES{1'b1}} << w_n) << r_cur_addr[LB-1:0];
  assign w_rem_after = r_remaining - r_len;
  assign w_abort     = r_abort_pend | abort_i;
  assign w_next = r_state == S_IDLE ? (go_i ? (desc_bytes_i == '0 ? S_DONE : S_CALC) : S_IDLE)
                : r_state == S_CALC ? (abort_i ? S_IDLE : S_REQ)
                : r_state == S_REQ  ? (!req_ready_i ? S_REQ : w_abort ? S_IDLE :
                                       w_rem_after == '0 ? S_DONE : S_CALC)
                : S_IDLE;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_len        <= '0;
      r_abort_pend <= 1'b0;
      req_valid_o  <= 1'b0;
      req_addr_o   <= '0;
      req_alen_o   <= '0;
      req_size_o   <= '0;
      req_strb_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      r_state      <= w_next;
      req_valid_o  <= w_next == S_REQ;
      busy_o       <= w_next != S_IDLE;
      done_o       <= w_next == S_DONE;
      r_abort_pend <= r_state == S_IDLE ? 1'b0 : r_abort_pend | (r_state == S_REQ && abort_i);
      if (r_state == S_IDLE && go_i) begin
        r_cur_addr  <= desc_addr_i;
        r_remaining <= desc_bytes_i;
      end
      if (r_state == S_CALC) begin
        req_addr_o <= r_cur_addr;
        req_alen_o <= w_full ? 8'(w_beats - BYTES_W'(1)) : 8'd0;
        req_size_o <= w_full ? 3'(LB) : w_nsize;
        req_strb_o <= w_strb;
        r_len      <= w_len;
      end
      if (r_state == S_REQ && req_ready_i) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(r_len);
        r_remaining <= w_rem_after;
      end
    end
  end
endmodule

// File: tb/tb_dma_streamer.sv
// tb_dma_streamer: scoreboard bench for dma_streamer with default parameters.
module tb_dma_streamer;
  logic        clk = 0, rstn = 0, go = 0, abort = 0, ready = 0;
  logic [31:0] d_addr = 0, d_bytes = 0;
  logic        valid, busy, done;
  logic [31:0] addr;
  logic [7:0]  alen;
  logic [2:0]  size;
  logic [63:0] strb;
  int          n_chk = 0, n_fail = 0, n_done = 0, n_hs = 0;
  logic [106:0] sb[$];

  dma_streamer dut (
    .clk(clk), .rstn(rstn), .go_i(go), .abort_i(abort),
    .desc_addr_i(d_addr), .desc_bytes_i(d_bytes),
    .req_valid_o(valid), .req_ready_i(ready), .req_addr_o(addr),
    .req_alen_o(alen), .req_size_o(size), .req_strb_o(strb),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [106:0] rq(logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [63:0] b);
    return {a, l, s, b};
  endfunction

  always @(negedge clk) begin
    if (done) n_done++;
    if (valid && ready) begin
      n_hs++;
      if (sb.size() == 0) check("unexpected_req", 1, 0);
      else check("req", {addr, alen, size, strb}, sb.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [31:0] a, logic [31:0] b);
    d_addr = a; d_bytes = b; go = 1;
    tick;
    go = 0;
  endtask

  task automatic run(logic [31:0] a, logic [31:0] b, int nd, int nh);
    int d0 = n_done, h0 = n_hs;
    start(a, b);
    ready = 1;
    for (int i = 0; i < 400 && busy; i++) tick;
    ready = 0;
    check("run_idle", busy, 0);
    check("run_done_cnt", n_done - d0, nd);
    check("run_hs_cnt", n_hs - h0, nh);
    check("run_sb_empty", sb.size(), 0);
  endtask

  initial begin
    int d0, h0;
    repeat (3) tick;
    check("rst_outs", {valid, busy, done, addr, alen, size, strb}, '0);
    rstn = 1;
    tick;
    // 1: single aligned burst with exact cycle timing
    sb.push_back(rq(32'h1000, 8'd3, 3'd6, '1));
    d0 = n_done; h0 = n_hs;
    start(32'h1000, 256);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_valid", valid, 0);
    tick;
    check("t1_c2_valid", valid, 1);
    ready = 1;
    tick;
    ready = 0;
    check("t1_done", {done, valid, busy}, 3'b101);
    tick;
    check("t1_after", {done, busy}, 2'b00);
    check("t1_done_cnt", n_done - d0, 1);
    check("t1_hs_cnt", n_hs - h0, 1);
    // 2: 4 KB boundary split
    sb.push_back(rq(32'h0FC0, 8'd0, 3'd6, '1));
    sb.push_back(rq(32'h1000, 8'd0, 3'd6, '1));
    run(32'h0FC0, 128, 1, 2);
    // 3: misaligned narrow beats
    sb.push_back(rq(32'h1003, 8'd0, 3'd0, 64'h8));
    sb.push_back(rq(32'h1004, 8'd0, 3'd2, 64'hF0));
    run(32'h1003, 5, 1, 2);
    // 4: long transfer split by page and beat limits
    for (int i = 0; i < 4; i++) sb.push_back(rq(32'h1000 * i, 8'd63, 3'd6, '1));
    sb.push_back(rq(32'h4000, 8'd43, 3'd6, '1));
    run(32'h0, 19200, 1, 5);
    // 5: backpressure with abort while waiting
    sb.push_back(rq(32'h1F00, 8'd3, 3'd6, '1));
    d0 = n_done; h0 = n_hs;
    start(32'h1F00, 512);
    for (int i = 0; i < 10 && !valid; i++) tick;
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", valid, 1);
      check("t5_hold_fields", {addr, alen, size, strb}, rq(32'h1F00, 8'd3, 3'd6, '1));
      abort = (i == 3);
      tick;
    end
    abort = 0;
    ready = 1;
    tick;
    check("t5_idle", {busy, valid, done}, 3'b000);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("t5_no_more", {busy, valid}, 2'b00);
    end
    ready = 0;
    check("t5_done_cnt", n_done - d0, 0);
    check("t5_hs_cnt", n_hs - h0, 1);
    check("t5_sb_empty", sb.size(), 0);
    // 6: zero-length descriptor
    d0 = n_done; h0 = n_hs;
    start(32'h2000, 0);
    check("t6_done_c1", {done, valid}, 2'b10);
    tick;
    check("t6_after", {done, busy}, 2'b00);
    check("t6_hs_cnt", n_hs - h0, 0);
    check("t6_done_cnt", n_done - d0, 1);
    // reset mid-operation, then a clean restart
    d0 = n_done;
    start(32'h5000, 1024);
    tick;
    check("t6_pre_rst_valid", valid, 1);
    rstn = 0;
    tick;
    check("t6_rst_outs", {valid, busy, done, addr, alen, size, strb}, '0);
    rstn = 1;
    tick;
    check("t6_rst_no_done", n_done - d0, 0);
    sb.push_back(rq(32'h1003, 8'd0, 3'd0, 64'h8));
    sb.push_back(rq(32'h1004, 8'd0, 3'd2, 64'hF0));
    run(32'h1003, 5, 1, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_streamer.md
# dma_streamer

Descriptor-to-burst splitter sitting directly upstream of the DMA AXI interface. One instance serves the read side and one the write side. Each takes a start address and byte count from the DMA FSM. It emits a sequence of AXI-legal requests (addr, alen, size, strb, valid) with a valid/ready handshake, and pulses done once every byte has been issued. Splitting enforces bus alignment, the 4 KB boundary and the maximum burst length.

## Interface
- ADDR_W, 32, address width
- BYTES_W, 32, byte-count width
- DATA_BYTES, 64, bus width in bytes (power of 2, 4..128)
- MAX_BEATS, 256, maximum beats per burst (power of 2, ≤256)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- go_i  in  1  start pulse; ignored unless IDLE
- abort_i  in  1  abort current descriptor
- desc_addr_i  in  ADDR_W  start address, sampled on go_i
- desc_bytes_i  in  BYTES_W  byte count, sampled on go_i
- req_valid_o  out  1  request valid
- req_ready_i  in  1  request accepted
- req_addr_o  out  ADDR_W  burst address
- req_alen_o  out  8  beats−1
- req_size_o  out  3  log2(bytes per beat)
- req_strb_o  out  DATA_BYTES  byte lanes of a narrow beat; all ones for full-width bursts
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on completion

## Operation
- FSM states: IDLE, CALC, REQ, DONE.
- IDLE + go_i:
  - Latch cur_addr and remaining.
  - Go to DONE if desc_bytes_i==0, else go to CALC.
- CALC computes the next request and registers all req_* fields. The next state is REQ.
- Full-width burst, taken when cur_addr[log2(DATA_BYTES)-1:0]==0 and remaining ≥ DATA_BYTES:
  - beats = min(remaining/DATA_BYTES, MAX_BEATS, (4096 − cur_addr[11:0])/DATA_BYTES)
  - alen = beats−1, size = log2(DATA_BYTES), strb = all ones
  - len_bytes = beats·DATA_BYTES
- Narrow single beat, used otherwise:
  - n = largest power of 2 such that n ≤ remaining, n ≤ DATA_BYTES, and cur_addr mod n == 0.
  - alen = 0, size = log2(n).
  - strb = ((1<<n)−1) << (cur_addr mod DATA_BYTES).
  - len_bytes = n.
- REQ holds req_valid_o=1 with stable fields until req_ready_i. On handshake:
  - cur_addr += len_bytes, remaining −= len_bytes.
  - Go to DONE if remaining==0, else go to CALC.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Abort:
  - In CALC or DONE, go to IDLE next cycle with no done pulse.
  - In REQ, keep valid asserted until handshake (AXI: valid never retracts), then go to IDLE with no done pulse.
  - abort_i is latched (abort_pend) if it pulses during REQ. abort_pend clears in IDLE.
- Arithmetic is unsigned. remaining never underflows because len_bytes ≤ remaining by construction. Address wrap past 2^ADDR_W is not checked.

## Timing
- Reset values:
  - state=IDLE; req_valid_o=0, busy_o=0, done_o=0.
  - req_addr_o, req_alen_o, req_size_o, req_strb_o, cur_addr, remaining and abort_pend all 0.
- All outputs are registered.
- go_i sampled at edge 0 → CALC during cycle 1 → req_valid_o high from cycle 2.
- Handshake at edge k → CALC in cycle k+1 → next valid in cycle k+2. There is one bubble per burst.
- Last handshake at edge k → done_o high in cycle k+1 and busy_o low in cycle k+2.
- Zero-length descriptor: go at edge 0 → done_o in cycle 1. No request is issued.
- Reset mid-operation returns to IDLE at the next edge. No done pulse; all outputs take their reset values.
- go_i while busy_o=1 has no effect.

## Test plan
1. addr 0x1000, 256 B → one request {0x1000, alen 3, size 6, strb all-ones}. valid in cycle 2, done one cycle after the handshake.
2. addr 0x0FC0, 128 B → {0x0FC0, alen 0}, then {0x1000, alen 0}; the 4 KB split is correct. Exactly two handshakes, then done.
3. addr 0x1003, 5 B → {0x1003, size 0, strb bit3}, then {0x1004, size 2, strb 0xF0}, then done.
4. addr 0x0, 19200 B → alen 63 at 0x0000, 0x1000, 0x2000 and 0x3000, then alen 43 at 0x4000. remaining reaches 0.
5. req_ready_i held low 10 cycles during a burst → valid and all fields stable throughout. abort_i pulsed while waiting → the request completes on ready, then IDLE, no done_o, no further requests.
6. desc_bytes=0 → done_o in cycle 1 and no valid. rstn low mid-sequence → all outputs reset next edge. A subsequent go_i starts cleanly.
